time_field_editor: RTL and testbench
====================================

// Module: time_field_editor
// PURPOSE
//  Parametrised button-driven editor for a multi-field time value (e.g. HH:MM:SS) used by clock/timer/chrono set modes.
//  On enable it loads the current value, then Left/Right move a cursor across fields and Up/Down increment/decrement
//  the selected field with per-field wrap limits; edits take effect in one cycle. Sits between debounced buttons and time-keeping cores.
// PARAMETERS
//  NUM_FIELDS    3                      number of editable fields (2..8); field 0 = leftmost (hours)
//  FIELD_W       8                      bits per field, unsigned binary
//  FIELD_MAX     {8'd59,8'd59,8'd23}    packed max per field, field i at [i*FIELD_W +: FIELD_W] (f0=23,f1=59,f2=59)
//  HOLD_CYCLES   50_000_000             auto-repeat initial delay (AUTO_REPEAT_EN only)
//  REPEAT_CYCLES 10_000_000             auto-repeat period (AUTO_REPEAT_EN only)
// PORTS
//  clk        in   1                    system clock, all logic on rising edge
//  reset      in   1                    asynchronous, active-low reset
//  en         in   1                    edit mode enable (level)
//  bt_up      in   1                    increment button (debounced level)
//  bt_down    in   1                    decrement button (debounced level)
//  bt_l       in   1                    cursor left
//  bt_r       in   1                    cursor right
//  fields_in  in   NUM_FIELDS*FIELD_W   value loaded on entry to edit
//  fields_out out  NUM_FIELDS*FIELD_W   edited value, registered
//  cursor     out  $clog2(NUM_FIELDS)   selected field index
//  changed    out  1                    one-cycle strobe when any field of fields_out changes by Up/Down
//  editing    out  1                    high in state EDIT
// BEHAVIOUR
//  Reset (reset=0, async): fields_out=0, cursor=0, changed=0, editing=0, state=IDLE, all button history regs=0.
//  Buttons: rising edge = level 1 now, 0 in previous registered sample; history tracked in all states, so a button held
//   while entering EDIT produces no event.
//  FSM: IDLE -(en=1)-> LOAD -> EDIT; any state -(en=0)-> IDLE next cycle. IDLE holds fields_out, forces cursor=0.
//  LOAD (1 cycle): fields_out[i] <= min(fields_in[i], FIELD_MAX[i]); cursor=0; editing=0.
//  EDIT, per cycle, using pre-edge cursor:
//   - R edge: cursor+1, NUM_FIELDS-1 wraps to 0. L edge: cursor-1, 0 wraps to NUM_FIELDS-1. L and R same cycle: no move.
//   - Up edge: field = (field>=MAX)?0:field+1. Down edge: field = (field==0)?MAX:field-1.
//   - Up and Down same cycle: no change, changed=0.
//   - Cursor move and Up/Down same cycle: value edit applies to the field at the old cursor.
//  Latency: button edge registered at cycle n -> fields_out/cursor updated at n+1; changed asserted at n+1 for one cycle.
//  en falling mid-edit: edits already registered are kept; pending edge in the same cycle is discarded.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: Up/Down held continuously in EDIT for HOLD_CYCLES after its edge produces a repeat event,
//   then one every REPEAT_CYCLES until release; repeat counter clears on release, on cursor move, on both Up+Down held,
//   and on leaving EDIT. Each repeat event behaves exactly as an edge (same wrap, same changed strobe).
//  Not defined: edges only; no repeat counter synthesised, HOLD_CYCLES/REPEAT_CYCLES unused.
// STRUCTURE
//  Package time_edit_pkg: state enum {IDLE,LOAD,EDIT}; default FIELD_MAX constants for HMS (23/59/59) and MS (59/59);
//   function fld_inc/fld_dec(value,max) implementing the wrap rules.
//  One sub-module: btn_repeat (edge detect + optional hold/repeat counter), instantiated once for Up and once for Down;
//   L/R use plain edge detect inside the top.
// TESTING
//  1. en 0->1 with fields_in=23:59:59 -> LOAD then EDIT; fields_out=23:59:59, cursor=0, editing=1 two cycles after en.
//  2. cursor=0, value 23, Up edge -> 00, changed pulse 1 cycle; Down edge on 00 -> 23; cursor=1 value 00 Down -> 59.
//  3. L edge at cursor 0 -> cursor 2; R edge at 2 -> 0; L+R same cycle -> cursor unchanged.
//  4. Up+Down same cycle -> no change, changed=0; Up + R same cycle at cursor 1 (value 10) -> field1=11, cursor=2.
//  5. fields_in field1=75 -> loaded as 59; bt_up held high across en rise -> no increment until released and re-pressed.
//  6. reset pulled low mid-EDIT (async, between edges) -> outputs 0 immediately; with AUTO_REPEAT_EN, HOLD=4, REPEAT=2,
//     Up held 10 cycles from value 0 -> values 1,2,3,4 (edge, +4, +6, +8).

Source files
------------

// File: rtl/time_field_editor_pkg.sv
// Shared types and wrap helpers for the time field editor.
// Optional auto-repeat is enabled by defining AUTO_REPEAT_EN.
package time_edit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EDIT
    } state_t;

    localparam int VW = 32;

    localparam logic [23:0] HMS_MAX = {8'd59, 8'd59, 8'd23};
    localparam logic [15:0] MS_MAX  = {8'd59, 8'd59};

    function automatic logic [VW-1:0] fld_inc(
        input logic [VW-1:0] v,
        input logic [VW-1:0] m
    );
        return (v >= m) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [VW-1:0] fld_dec(
        input logic [VW-1:0] v,
        input logic [VW-1:0] m
    );
        return (v == '0) ? m : v - 1'b1;
    endfunction

endpackage

// File: rtl/time_field_editor_if.sv
// Button inputs and edited-value outputs of the time field editor.
// Master drives buttons/enable/load value; slave is the editor.
interface time_field_editor_if #(
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = 8
);
    localparam int CW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    logic                          en;
    logic                          bt_up;
    logic                          bt_down;
    logic                          bt_l;
    logic                          bt_r;
    logic [NUM_FIELDS*FIELD_W-1:0] fields_in;
    logic [NUM_FIELDS*FIELD_W-1:0] fields_out;
    logic [CW-1:0]                 cursor;
    logic                          changed;
    logic                          editing;

    modport master (
        output en, bt_up, bt_down, bt_l, bt_r, fields_in,
        input  fields_out, cursor, changed, editing
    );

    modport slave (
        input  en, bt_up, bt_down, bt_l, bt_r, fields_in,
        output fields_out, cursor, changed, editing
    );

endinterface

// File: rtl/time_field_editor_btn_repeat.sv
// Rising-edge detect for one button, plus hold/auto-repeat events
// when AUTO_REPEAT_EN is defined.
module btn_repeat #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    input  logic i_act,
    input  logic i_clr,
    output logic o_evt
);
    logic r_prev;
    logic w_edge;

    assign w_edge = i_btn & ~r_prev;

    // previous-sample history, tracked in every state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_prev <= 1'b0;
        else        r_prev <= i_btn;
    end

`ifdef AUTO_REPEAT_EN
    logic [31:0] r_cnt;
    logic        r_phase;
    logic [31:0] w_lim;
    logic        w_hold;
    logic        w_rep;

    assign w_hold = i_btn & i_act & ~i_clr;
    assign w_lim  = r_phase ? 32'(REPEAT_CYCLES) : 32'(HOLD_CYCLES);
    assign w_rep  = w_hold && (r_cnt != '0) && (r_cnt == w_lim);
    assign o_evt  = w_edge | w_rep;

    // cycles since edge/last repeat; 0 means not armed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!w_hold) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_edge) begin
            r_cnt   <= 32'd1;
            r_phase <= 1'b0;
        end else if (w_rep) begin
            r_cnt   <= 32'd1;
            r_phase <= 1'b1;
        end else if (r_cnt != '0) begin
            r_cnt   <= r_cnt + 32'd1;
        end
    end
`else
    logic w_unused_cfg;

    assign o_evt = w_edge;
    assign w_unused_cfg = ^{i_act, i_clr,
                            HOLD_CYCLES[0], REPEAT_CYCLES[0]};
`endif

endmodule

// File: rtl/time_field_editor.sv
// Button-driven multi-field time editor (load, cursor, wrap edit).
// Define AUTO_REPEAT_EN for hold-to-repeat on Up/Down.
module time_field_editor
    import time_edit_pkg::*;
#(
    parameter int NUM_FIELDS    = 3,
    parameter int FIELD_W       = 8,
    parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX = HMS_MAX,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic                clk,
    input  logic                reset,
    time_field_editor_if.slave  bus
);
    localparam int CW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int W  = NUM_FIELDS * FIELD_W;
    localparam logic [CW-1:0] LAST = CW'(NUM_FIELDS - 1);

    state_t           r_state, w_state_n;
    logic [W-1:0]     r_fields, w_fields_n;
    logic [CW-1:0]    r_cursor, w_cursor_n;
    logic             r_changed, w_changed_n;
    logic             r_l_prev, r_r_prev;
    logic             w_l_edge, w_r_edge;
    logic             w_up_evt, w_dn_evt;
    logic             w_act, w_move;
    logic [FIELD_W-1:0] w_sel, w_max, w_new;

    assign w_act    = (r_state == EDIT) && bus.en;
    assign w_l_edge = bus.bt_l & ~r_l_prev;
    assign w_r_edge = bus.bt_r & ~r_r_prev;
    assign w_move   = w_act && (w_l_edge ^ w_r_edge);

    btn_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_up (
        .clk  (clk),
        .reset(reset),
        .i_btn(bus.bt_up),
        .i_act(w_act),
        .i_clr(w_move | (bus.bt_up & bus.bt_down)),
        .o_evt(w_up_evt)
    );

    btn_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_dn (
        .clk  (clk),
        .reset(reset),
        .i_btn(bus.bt_down),
        .i_act(w_act),
        .i_clr(w_move | (bus.bt_up & bus.bt_down)),
        .o_evt(w_dn_evt)
    );

    // state, value, cursor and L/R history registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_fields  <= '0;
            r_cursor  <= '0;
            r_changed <= 1'b0;
            r_l_prev  <= 1'b0;
            r_r_prev  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_fields  <= w_fields_n;
            r_cursor  <= w_cursor_n;
            r_changed <= w_changed_n;
            r_l_prev  <= bus.bt_l;
            r_r_prev  <= bus.bt_r;
        end
    end

    // next state: enable drops to IDLE from anywhere
    always_comb begin
        w_state_n = r_state;
        if (!bus.en) begin
            w_state_n = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    w_state_n = LOAD;
                LOAD:    w_state_n = EDIT;
                EDIT:    w_state_n = EDIT;
                default: w_state_n = IDLE;
            endcase
        end
    end

    // load clamp, cursor move and field edit at pre-edge cursor
    always_comb begin
        w_fields_n  = r_fields;
        w_cursor_n  = '0;
        w_changed_n = 1'b0;
        w_sel       = r_fields[r_cursor*FIELD_W +: FIELD_W];
        w_max       = FIELD_MAX[r_cursor*FIELD_W +: FIELD_W];
        w_new       = w_sel;
        if (r_state == LOAD && bus.en) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                w_fields_n[i*FIELD_W +: FIELD_W] =
                    (bus.fields_in[i*FIELD_W +: FIELD_W] >
                     FIELD_MAX[i*FIELD_W +: FIELD_W]) ?
                    FIELD_MAX[i*FIELD_W +: FIELD_W] :
                    bus.fields_in[i*FIELD_W +: FIELD_W];
            end
        end
        if (w_act) begin
            w_cursor_n = r_cursor;
            if (w_move && w_r_edge)
                w_cursor_n = (r_cursor == LAST) ? '0 : r_cursor + 1'b1;
            else if (w_move && w_l_edge)
                w_cursor_n = (r_cursor == '0) ? LAST : r_cursor - 1'b1;
            if (w_up_evt ^ w_dn_evt) begin
                if (w_up_evt)
                    w_new = FIELD_W'(fld_inc(VW'(w_sel), VW'(w_max)));
                else
                    w_new = FIELD_W'(fld_dec(VW'(w_sel), VW'(w_max)));
                w_fields_n[r_cursor*FIELD_W +: FIELD_W] = w_new;
                w_changed_n = (w_new != w_sel);
            end
        end
    end

    assign bus.fields_out = r_fields;
    assign bus.cursor     = r_cursor;
    assign bus.changed    = r_changed;
    assign bus.editing    = (r_state == EDIT);

endmodule

// File: tb/tb_time_field_editor.sv
// Scoreboard bench for time_field_editor (HMS, 3 fields of 8 bits).
// Repeat expectations follow AUTO_REPEAT_EN with HOLD=4, REPEAT=2.
module tb_time_field_editor;

    typedef struct packed {
        logic [23:0] f;
        logic [1:0]  c;
        logic        ch;
        logic        ed;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    time_field_editor_if #(.NUM_FIELDS(3), .FIELD_W(8)) bus ();

    time_field_editor #(
        .NUM_FIELDS   (3),
        .FIELD_W      (8),
        .FIELD_MAX    ({8'd59, 8'd59, 8'd23}),
        .HOLD_CYCLES  (4),
        .REPEAT_CYCLES(2)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] hms(int h, int m, int s);
        return {8'(s), 8'(m), 8'(h)};
    endfunction

    function automatic exp_t mk(logic [23:0] f, int c, logic ch,
                                logic ed);
        exp_t e;
        e.f  = f;
        e.c  = 2'(c);
        e.ch = ch;
        e.ed = ed;
        return e;
    endfunction

    function automatic exp_t obs();
        return mk(bus.fields_out, int'(bus.cursor), bus.changed,
                  bus.editing);
    endfunction

    task automatic drive(logic [4:0] s);
        {bus.en, bus.bt_up, bus.bt_down, bus.bt_l, bus.bt_r} = s;
    endtask

    task automatic test_reset();
        exp_t g, e;
        drive(5'b00000);
        bus.fields_in = hms(1, 2, 3);
        rst_n = 1'b0;
        sb.push_back(mk('0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        g = obs();
        e = sb.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_hold got=%h want=%h", g, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk('0, 0, 0, 0));
        @(posedge clk);
        #1;
        g = obs();
        e = sb.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL reset_idle got=%h want=%h", g, e);
        end
    endtask

    task automatic test_load();
        logic [4:0] st [2];
        exp_t       ex [2];
        exp_t       g, e;
        bus.fields_in = hms(23, 59, 59);
        st[0] = 5'b10000; ex[0] = mk('0, 0, 0, 0);
        st[1] = 5'b10000; ex[1] = mk(hms(23, 59, 59), 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(st[k]);
            sb.push_back(ex[k]);
            @(posedge clk);
            #1;
            g = obs();
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL load step %0d got=%h want=%h", k, g, e);
            end
        end
    endtask

    task automatic test_updown();
        logic [4:0] st [10];
        exp_t       ex [10];
        exp_t       g, e;
        st[0] = 5'b11000; ex[0] = mk(hms(0, 59, 59), 0, 1, 1);
        st[1] = 5'b10000; ex[1] = mk(hms(0, 59, 59), 0, 0, 1);
        st[2] = 5'b10100; ex[2] = mk(hms(23, 59, 59), 0, 1, 1);
        st[3] = 5'b10000; ex[3] = mk(hms(23, 59, 59), 0, 0, 1);
        st[4] = 5'b10001; ex[4] = mk(hms(23, 59, 59), 1, 0, 1);
        st[5] = 5'b10000; ex[5] = mk(hms(23, 59, 59), 1, 0, 1);
        st[6] = 5'b11000; ex[6] = mk(hms(23, 0, 59), 1, 1, 1);
        st[7] = 5'b10000; ex[7] = mk(hms(23, 0, 59), 1, 0, 1);
        st[8] = 5'b10100; ex[8] = mk(hms(23, 59, 59), 1, 1, 1);
        st[9] = 5'b10000; ex[9] = mk(hms(23, 59, 59), 1, 0, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(st[k]);
            sb.push_back(ex[k]);
            @(posedge clk);
            #1;
            g = obs();
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL updown step %0d got=%h want=%h", k, g, e);
            end
        end
    endtask

    task automatic test_cursor();
        logic [4:0] st [8];
        int         cx [8];
        exp_t       g, e;
        st[0] = 5'b10010; cx[0] = 0;
        st[1] = 5'b10000; cx[1] = 0;
        st[2] = 5'b10010; cx[2] = 2;
        st[3] = 5'b10000; cx[3] = 2;
        st[4] = 5'b10011; cx[4] = 2;
        st[5] = 5'b10000; cx[5] = 2;
        st[6] = 5'b10001; cx[6] = 0;
        st[7] = 5'b10000; cx[7] = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(st[k]);
            sb.push_back(mk(hms(23, 59, 59), cx[k], 0, 1));
            @(posedge clk);
            #1;
            g = obs();
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cursor step %0d got=%h want=%h", k, g, e);
            end
        end
    endtask

    task automatic test_combo();
        logic [4:0] st [9];
        exp_t       ex [9];
        exp_t       g, e;
        bus.fields_in = hms(5, 10, 30);
        st[0] = 5'b11100; ex[0] = mk(hms(23, 59, 59), 0, 0, 1);
        st[1] = 5'b10000; ex[1] = mk(hms(23, 59, 59), 0, 0, 1);
        st[2] = 5'b00000; ex[2] = mk(hms(23, 59, 59), 0, 0, 0);
        st[3] = 5'b10000; ex[3] = mk(hms(23, 59, 59), 0, 0, 0);
        st[4] = 5'b10000; ex[4] = mk(hms(5, 10, 30), 0, 0, 1);
        st[5] = 5'b10001; ex[5] = mk(hms(5, 10, 30), 1, 0, 1);
        st[6] = 5'b10000; ex[6] = mk(hms(5, 10, 30), 1, 0, 1);
        st[7] = 5'b11001; ex[7] = mk(hms(5, 11, 30), 2, 1, 1);
        st[8] = 5'b10000; ex[8] = mk(hms(5, 11, 30), 2, 0, 1);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            drive(st[k]);
            sb.push_back(ex[k]);
            @(posedge clk);
            #1;
            g = obs();
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL combo step %0d got=%h want=%h", k, g, e);
            end
        end
    endtask

    task automatic test_clamp_hold();
        logic [4:0] st [7];
        exp_t       ex [7];
        exp_t       g, e;
        bus.fields_in = hms(12, 75, 30);
        st[0] = 5'b01000; ex[0] = mk(hms(5, 11, 30), 0, 0, 0);
        st[1] = 5'b11000; ex[1] = mk(hms(5, 11, 30), 0, 0, 0);
        st[2] = 5'b11000; ex[2] = mk(hms(12, 59, 30), 0, 0, 1);
        st[3] = 5'b11000; ex[3] = mk(hms(12, 59, 30), 0, 0, 1);
        st[4] = 5'b10000; ex[4] = mk(hms(12, 59, 30), 0, 0, 1);
        st[5] = 5'b11000; ex[5] = mk(hms(13, 59, 30), 0, 1, 1);
        st[6] = 5'b10000; ex[6] = mk(hms(13, 59, 30), 0, 0, 1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drive(st[k]);
            sb.push_back(ex[k]);
            @(posedge clk);
            #1;
            g = obs();
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL clamp step %0d got=%h want=%h", k, g, e);
            end
        end
    endtask

    task automatic test_repeat();
        logic [4:0] st [14];
        exp_t       ex [14];
        exp_t       g, e;
        int         v;
        logic       p;
        bus.fields_in = hms(0, 0, 0);
        st[0] = 5'b00000; ex[0] = mk(hms(13, 59, 30), 0, 0, 0);
        st[1] = 5'b10000; ex[1] = mk(hms(13, 59, 30), 0, 0, 0);
        st[2] = 5'b10000; ex[2] = mk(hms(0, 0, 0), 0, 0, 1);
        for (int k = 0; k < 10; k++) begin
`ifdef AUTO_REPEAT_EN
            v = (k < 4) ? 1 : (k < 6) ? 2 : (k < 8) ? 3 : 4;
            p = (k == 0 || k == 4 || k == 6 || k == 8);
`else
            v = 1;
            p = (k == 0);
`endif
            st[3+k] = 5'b11000;
            ex[3+k] = mk(hms(v, 0, 0), 0, p, 1);
        end
        st[13] = 5'b10000;
        ex[13] = mk(ex[12].f, 0, 0, 1);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            drive(st[k]);
            sb.push_back(ex[k]);
            @(posedge clk);
            #1;
            g = obs();
            e = sb.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL repeat step %0d got=%h want=%h", k, g, e);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t g, e;
        logic [23:0] f;
`ifdef AUTO_REPEAT_EN
        f = hms(4, 0, 0);
`else
        f = hms(1, 0, 0);
`endif
        @(negedge clk);
        drive(5'b10001);
        sb.push_back(mk(f, 1, 0, 1));
        @(posedge clk);
        #1;
        g = obs();
        e = sb.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL pre_reset got=%h want=%h", g, e);
        end
        @(negedge clk);
        drive(5'b10000);
        #2;
        rst_n = 1'b0;
        sb.push_back(mk('0, 0, 0, 0));
        #1;
        g = obs();
        e = sb.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", g, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'b10000);
        sb.push_back(mk('0, 0, 0, 0));
        @(posedge clk);
        #1;
        g = obs();
        e = sb.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL post_reset got=%h want=%h", g, e);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_updown();
        test_cursor();
        test_combo();
        test_clamp_hold();
        test_repeat();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
